systolic_seq: RTL and testbench

- Sequencer for a 2x2 array of tt_um_machinaut_systolic tiles.
- Holds operand nibbles for two array rows (A) and two array columns (B), loaded by a host write port.
- On start, streams A into the row inputs and B into the column inputs, with a one-cycle diagonal skew on lane 1 and per-lane control (valid) bits.
- Then waits for the array to drain, captures valid column-output nibbles into a result buffer, and pulses done.

---
 rtl/systolic_seq_if.sv | 49 ++++
 rtl/systolic_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_systolic_seq.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_if.sv
// ---------------------------------------------------------------------------
// systolic_seq_if
// Bundles every non-clock, non-reset signal of the 2x2 systolic sequencer.
//   Host side   : ena, cfg_k, wr_* operand write port, start, busy, done,
//                 rd_lane/rd_addr/rd_data result read port, res_cnt.
//   Array side  : row_in/row_ctrl_in, col_in/col_ctrl_in (sequencer drives),
//                 col_out/col_ctrl_out (array returns).
// Packing on all 8-bit buses: lane 0 on [7:4], lane 1 on [3:0].
// Packing on all 2-bit valid buses: bit 1 = lane 0, bit 0 = lane 1.
// Modports:
//   master - host + array environment (drives control, consumes drive)
//   slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface systolic_seq_if;
    logic       ena;
    logic [3:0] cfg_k;
    logic       wr_en;
    logic       wr_sel;
    logic       wr_lane;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic [7:0] row_in;
    logic [1:0] row_ctrl_in;
    logic [7:0] col_in;
    logic [1:0] col_ctrl_in;
    logic [7:0] col_out;
    logic [1:0] col_ctrl_out;
    logic       rd_lane;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;
    logic [5:0] res_cnt;

    modport master (
        output ena, cfg_k, wr_en, wr_sel, wr_lane, wr_addr, wr_data, start,
        output col_out, col_ctrl_out, rd_lane, rd_addr,
        input  busy, done, row_in, row_ctrl_in, col_in, col_ctrl_in,
        input  rd_data, res_cnt
    );

    modport slave (
        input  ena, cfg_k, wr_en, wr_sel, wr_lane, wr_addr, wr_data, start,
        input  col_out, col_ctrl_out, rd_lane, rd_addr,
        output busy, done, row_in, row_ctrl_in, col_in, col_ctrl_in,
        output rd_data, res_cnt
    );
endinterface

// File: rtl/systolic_seq.sv
// ---------------------------------------------------------------------------
// systolic_seq
// Sequencer for a 2x2 systolic tile array. The host loads operand nibbles
// for two rows (A) and two columns (B); on start the block streams them
// into the array (lane 1 delayed one cycle behind lane 0), idles while the
// array drains, captures valid column results into a small buffer, and
// pulses done.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - systolic_seq_if.slave (host write/read/control + array I/O)
// ---------------------------------------------------------------------------
module systolic_seq #(
    parameter int K_MAX     = 8,   // operand entries per lane, power of 2, <= 8
    parameter int DRAIN     = 4,   // idle cycles after the feed phase
    parameter int OUT_BEATS = 4    // capture cycles / result entries per lane
) (
    input  logic           clk,
    input  logic           rst_n,
    systolic_seq_if.slave  bus
);
    localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
    localparam int RW = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    t_reg, t_next;
    logic [3:0]    kc_reg, kc_next;
    logic [3:0]    kc_clamped;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [7:0]    row_next, col_next;
    logic [1:0]    row_ctrl_next, col_ctrl_next;
    logic [7:0]    row_in_reg, col_in_reg;
    logic [1:0]    row_ctrl_reg, col_ctrl_reg;
    logic          busy_reg, done_reg;
    logic          rd_lane_reg;

    logic [1:0][3:0] rd_q;
    logic [1:0][2:0] ptr_w;

    logic idle_start;
    logic capture_active;

    assign idle_start     = (state_reg == S_IDLE) && bus.start;
    assign capture_active = (state_reg == S_DRAIN) || (state_reg == S_CAPT);

    always_comb begin
        kc_clamped = bus.cfg_k;
        if (bus.cfg_k == 4'd0) begin
            kc_clamped = 4'd1;
        end else if (bus.cfg_k > 4'(K_MAX)) begin
            kc_clamped = 4'(K_MAX);
        end
    end

    // Next-state logic; t_reg indexes the feed beat, cnt_reg times DRAIN/CAPT.
    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        kc_next    = kc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FEED;
                    t_next     = 4'd0;
                    kc_next    = kc_clamped;
                end
            end
            S_FEED: begin
                if (t_reg == kc_reg) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end else begin
                    t_next = t_reg + 4'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_reg == CW'(DRAIN - 1)) begin
                    state_next = S_CAPT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_CAPT: begin
                if (cnt_reg == CW'(OUT_BEATS - 1)) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else if (bus.ena) begin
            state_reg <= state_next;
        end
    end

    // Array drive is computed from the *next* state/beat so that the
    // registered value seen in a cycle belongs to that cycle's state and t.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_reg        <= 4'd0;
            kc_reg       <= 4'd1;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            row_in_reg   <= 8'h00;
            col_in_reg   <= 8'h00;
            row_ctrl_reg <= 2'b00;
            col_ctrl_reg <= 2'b00;
            rd_lane_reg  <= 1'b0;
        end else if (bus.ena) begin
            t_reg        <= t_next;
            kc_reg       <= kc_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= (state_next != S_IDLE);
            done_reg     <= (state_next == S_DONE);
            row_in_reg   <= row_next;
            col_in_reg   <= col_next;
            row_ctrl_reg <= row_ctrl_next;
            col_ctrl_reg <= col_ctrl_next;
            rd_lane_reg  <= bus.rd_lane;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic [3:0] a_mem [0:K_MAX-1];
        logic [3:0] b_mem [0:K_MAX-1];
        logic [3:0] r_mem [0:OUT_BEATS-1];
        logic [2:0] ptr_reg;
        logic [3:0] rd_q_reg;
        logic [4:0] tap;
        logic       valid;
        logic       cap_hit;

        // Lane gi reads entry t-gi; a negative tap (bit 4 set) means the
        // skewed lane has not started yet.
        assign tap   = {1'b0, t_next} - 5'(gi);
        assign valid = (state_next == S_FEED) && !tap[4] && (tap[3:0] < kc_next);

        assign row_next[7-4*gi -: 4] = valid ? a_mem[tap[AW-1:0]] : 4'h0;
        assign col_next[7-4*gi -: 4] = valid ? b_mem[tap[AW-1:0]] : 4'h0;
        assign row_ctrl_next[1-gi]   = valid;
        assign col_ctrl_next[1-gi]   = valid;

        always_ff @(posedge clk) begin
            if (rst_n && bus.ena && (state_reg == S_IDLE) && bus.wr_en &&
                (bus.wr_lane == 1'(gi))) begin
                if (bus.wr_sel) begin
                    b_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
                end else begin
                    a_mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
                end
            end
        end

        assign cap_hit = capture_active && bus.col_ctrl_out[1-gi] &&
                         (ptr_reg < 3'(OUT_BEATS));

        // Pointer saturates at OUT_BEATS; extra valid beats are dropped.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                ptr_reg <= 3'd0;
            end else if (bus.ena) begin
                if (idle_start) begin
                    ptr_reg <= 3'd0;
                end else if (cap_hit) begin
                    ptr_reg <= ptr_reg + 3'd1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst_n && bus.ena && cap_hit) begin
                r_mem[ptr_reg[RW-1:0]] <= bus.col_out[7-4*gi -: 4];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_q_reg <= 4'h0;
            end else if (bus.ena) begin
                rd_q_reg <= r_mem[bus.rd_addr[RW-1:0]];
            end
        end

        assign rd_q[gi]  = rd_q_reg;
        assign ptr_w[gi] = ptr_reg;
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.row_in      = row_in_reg;
    assign bus.row_ctrl_in = row_ctrl_reg;
    assign bus.col_in      = col_in_reg;
    assign bus.col_ctrl_in = col_ctrl_reg;
    // Both lanes read every cycle; the registered lane select picks one.
    assign bus.rd_data     = rd_lane_reg ? rd_q[1] : rd_q[0];
    assign bus.res_cnt     = {ptr_w[0], ptr_w[1]};

endmodule

// File: tb/tb_systolic_seq.sv
// ---------------------------------------------------------------------------
// tb_systolic_seq
// Self-checking bench for systolic_seq. A behavioural model holds the operand
// and result buffers and predicts, per busy-cycle index c, the array drive:
// lane 0 carries entry c while c < K, lane 1 carries entry c-1 while
// 1 <= c <= K, everything else is zero. Capture is predicted over the window
// of busy cycles after the feed phase and before the done cycle.
// ---------------------------------------------------------------------------
module tb_systolic_seq;
    localparam int K_MAX     = 8;
    localparam int DRAIN     = 4;
    localparam int OUT_BEATS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    systolic_seq_if bus();

    systolic_seq #(
        .K_MAX(K_MAX),
        .DRAIN(DRAIN),
        .OUT_BEATS(OUT_BEATS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [3:0] ma [2][8];
    logic [3:0] mb [2][8];
    logic [3:0] mr [2][4];
    bit         mr_ok [2][4];
    int         mcnt [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_op(input bit sel, input bit lane, input int addr,
                            input logic [3:0] d, input bit upd);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_lane = lane;
        bus.wr_addr = 3'(addr);
        bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
        if (upd) begin
            if (sel) mb[lane][addr] = d;
            else     ma[lane][addr] = d;
        end
    endtask

    // Runs one job. cap_mode: 0 none, 1 random, 2 five directed beats.
    // freeze_at/abort_at: busy-cycle index for ena drop / reset, -1 = off.
    task automatic run_job(input int cfg, input int freeze_at, input int cap_mode,
                           input bit noise, input int abort_at);
        int kc, total, b;
        logic [7:0] er, ec, co;
        logic [1:0] erc, ecc, cc;
        bit in_win;
        kc = (cfg == 0) ? 1 : ((cfg > K_MAX) ? K_MAX : cfg);
        total = kc + 1 + DRAIN + OUT_BEATS + 1;
        mcnt[0] = 0;
        mcnt[1] = 0;
        bus.cfg_k = 4'(cfg);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.cfg_k = 4'($urandom_range(0, 15));
        for (int c = 0; c < total; c++) begin
            er = 8'h00; ec = 8'h00; erc = 2'b00; ecc = 2'b00;
            if (c < kc) begin
                er[7:4] = ma[0][c]; ec[7:4] = mb[0][c]; erc[1] = 1'b1; ecc[1] = 1'b1;
            end
            if (c >= 1 && c <= kc) begin
                er[3:0] = ma[1][c-1]; ec[3:0] = mb[1][c-1]; erc[0] = 1'b1; ecc[0] = 1'b1;
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== (c == total - 1)) begin
                errors++;
                $display("FAIL busy_done k=%0d c=%0d: got busy=%b done=%b, want busy=1 done=%b",
                         kc, c, bus.busy, bus.done, (c == total - 1));
            end
            checks++;
            if (bus.row_in !== er || bus.row_ctrl_in !== erc) begin
                errors++;
                $display("FAIL row_drive k=%0d c=%0d: got %h/%b, want %h/%b",
                         kc, c, bus.row_in, bus.row_ctrl_in, er, erc);
            end
            checks++;
            if (bus.col_in !== ec || bus.col_ctrl_in !== ecc) begin
                errors++;
                $display("FAIL col_drive k=%0d c=%0d: got %h/%b, want %h/%b",
                         kc, c, bus.col_in, bus.col_ctrl_in, ec, ecc);
            end
            if (c == abort_at) begin
                bus.col_ctrl_out = 2'b00;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                mcnt[0] = 0;
                mcnt[1] = 0;
                checks++;
                if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.row_in !== 8'h00 ||
                    bus.col_in !== 8'h00 || bus.row_ctrl_in !== 2'b00 ||
                    bus.col_ctrl_in !== 2'b00 || bus.res_cnt !== 6'd0) begin
                    errors++;
                    $display("FAIL abort_state: got busy=%b done=%b row=%h col=%h ctrl=%b/%b cnt=%b, want all 0",
                             bus.busy, bus.done, bus.row_in, bus.col_in,
                             bus.row_ctrl_in, bus.col_ctrl_in, bus.res_cnt);
                end
                for (int i = 0; i < 20; i++) begin
                    tick();
                    checks++;
                    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                        errors++;
                        $display("FAIL abort_idle i=%0d: got busy=%b done=%b, want 0/0",
                                 i, bus.busy, bus.done);
                    end
                end
                return;
            end
            if (c == freeze_at) begin
                bus.ena = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    tick();
                    checks++;
                    if (bus.busy !== 1'b1 || bus.row_in !== er || bus.row_ctrl_in !== erc ||
                        bus.col_in !== ec || bus.done !== 1'b0) begin
                        errors++;
                        $display("FAIL freeze_hold i=%0d: got busy=%b row=%h/%b col=%h, want 1 %h/%b %h",
                                 i, bus.busy, bus.row_in, bus.row_ctrl_in, bus.col_in, er, erc, ec);
                    end
                end
                bus.ena = 1'b1;
            end
            in_win = (c >= kc + 1) && (c <= kc + DRAIN + OUT_BEATS);
            cc = 2'b00;
            co = 8'h00;
            if (cap_mode == 1) begin
                cc = 2'($urandom_range(0, 3));
                co = 8'($urandom_range(0, 255));
            end else if (cap_mode == 2) begin
                b = c - (kc + 1);
                if (in_win && b < 5) begin
                    cc = 2'b11;
                    co = {4'(b + 1), 4'(15 - b)};
                end
            end
            bus.col_ctrl_out = cc;
            bus.col_out      = co;
            if (in_win) begin
                for (int l = 0; l < 2; l++) begin
                    if (cc[1-l] && mcnt[l] < OUT_BEATS) begin
                        mr[l][mcnt[l]]    = (l == 0) ? co[7:4] : co[3:0];
                        mr_ok[l][mcnt[l]] = 1'b1;
                        mcnt[l]++;
                    end
                end
            end
            if (noise) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'($urandom_range(0, 1));
                bus.wr_lane = 1'($urandom_range(0, 1));
                bus.wr_addr = 3'($urandom_range(0, 7));
                bus.wr_data = 4'($urandom_range(0, 15));
                bus.start   = 1'b1;
                bus.cfg_k   = 4'($urandom_range(0, 15));
            end
            tick();
        end
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        bus.col_ctrl_out = 2'b00;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.row_ctrl_in !== 2'b00 ||
            bus.col_ctrl_in !== 2'b00) begin
            errors++;
            $display("FAIL job_end k=%0d: got busy=%b done=%b ctrl=%b/%b, want all 0",
                     kc, bus.busy, bus.done, bus.row_ctrl_in, bus.col_ctrl_in);
        end
        checks++;
        if (bus.res_cnt !== {3'(mcnt[0]), 3'(mcnt[1])}) begin
            errors++;
            $display("FAIL res_cnt k=%0d: got %b, want %b", kc, bus.res_cnt,
                     {3'(mcnt[0]), 3'(mcnt[1])});
        end
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < OUT_BEATS; a++) begin
                if (mr_ok[l][a]) begin
                    bus.rd_lane = 1'(l);
                    bus.rd_addr = 2'(a);
                    tick();
                    checks++;
                    if (bus.rd_data !== mr[l][a]) begin
                        errors++;
                        $display("FAIL rd_data lane=%0d addr=%0d: got %h, want %h",
                                 l, a, bus.rd_data, mr[l][a]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.row_ctrl_in !== 2'b00 ||
            bus.col_ctrl_in !== 2'b00 || bus.rd_data !== 4'h0 || bus.res_cnt !== 6'd0 ||
            bus.row_in !== 8'h00 || bus.col_in !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: got busy=%b done=%b ctrl=%b/%b rd=%h cnt=%b row=%h col=%h, want all 0",
                     bus.busy, bus.done, bus.row_ctrl_in, bus.col_ctrl_in,
                     bus.rd_data, bus.res_cnt, bus.row_in, bus.col_in);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_feed_skew();
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < K_MAX; a++) begin
                write_op(1'b0, 1'(l), a, 4'($urandom_range(0, 15)), 1'b1);
                write_op(1'b1, 1'(l), a, 4'($urandom_range(0, 15)), 1'b1);
            end
        end
        for (int a = 0; a < 3; a++) begin
            write_op(1'b0, 1'b0, a, 4'(1 + a), 1'b1);
            write_op(1'b0, 1'b1, a, 4'(4 + a), 1'b1);
            write_op(1'b1, 1'b0, a, 4'(7 + a), 1'b1);
            write_op(1'b1, 1'b1, a, 4'(10 + a), 1'b1);
        end
        run_job(3, -1, 0, 1'b0, -1);
    endtask

    task automatic test_capture();
        run_job(3, -1, 2, 1'b0, -1);
    endtask

    task automatic test_clamp();
        run_job(0, -1, 1, 1'b0, -1);
        run_job(15, -1, 1, 1'b0, -1);
    endtask

    task automatic test_ignore_busy();
        run_job(5, -1, 1, 1'b1, -1);
        run_job(8, -1, 0, 1'b0, -1);
    endtask

    task automatic test_ena_freeze();
        bus.ena = 1'b0;
        write_op(1'b0, 1'b0, 1, ~ma[0][1], 1'b0);
        write_op(1'b1, 1'b1, 0, ~mb[1][0], 1'b0);
        bus.ena = 1'b1;
        run_job(3, 1, 0, 1'b0, -1);
    endtask

    task automatic test_abort();
        run_job(4, -1, 1, 1'b0, 4 + 1 + 2);
        run_job(4, -1, 1, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            for (int n = 0; n < 6; n++) begin
                write_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(0, K_MAX - 1), 4'($urandom_range(0, 15)), 1'b1);
            end
            run_job($urandom_range(0, 15), -1, 1, 1'b0, -1);
        end
    endtask

    initial begin
        bus.ena          = 1'b1;
        bus.cfg_k        = 4'd0;
        bus.wr_en        = 1'b0;
        bus.wr_sel       = 1'b0;
        bus.wr_lane      = 1'b0;
        bus.wr_addr      = 3'd0;
        bus.wr_data      = 4'h0;
        bus.start        = 1'b0;
        bus.col_out      = 8'h00;
        bus.col_ctrl_out = 2'b00;
        bus.rd_lane      = 1'b0;
        bus.rd_addr      = 2'd0;
        for (int l = 0; l < 2; l++) begin
            for (int a = 0; a < 4; a++) mr_ok[l][a] = 1'b0;
        end
        test_reset();
        test_feed_skew();
        test_capture();
        test_clamp();
        test_ignore_busy();
        test_ena_freeze();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
